// File: rtl/approx_mul_seq_if.sv
// approx_mul_seq_if: operand/result handshake bundle for the sequential
// approximate multiplier. The master drives operands and consumes results;
// the slave is the multiplier itself.
interface approx_mul_seq_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/approx_mul_seq.sv
// approx_mul_seq: sequential truncation-based approximate unsigned multiplier.
// One shift-and-add partial product per cycle; stops as soon as no set
// multiplier bits remain. The TRUNC least-significant columns of every
// partial product are dropped.
// Optional feature macro: APPROX_MUL_ERR_COMP_EN -- when defined the
// accumulator starts at 2^(TRUNC-1) to bias out the mean truncation error.
module approx_mul_seq #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  approx_mul_seq_if.slave    bus
);

  localparam int PW = 2 * WIDTH;

  // Columns below TRUNC are forced to zero in every partial product.
  localparam logic [PW-1:0] MASK = {PW{1'b1}} << TRUNC;

`ifdef APPROX_MUL_ERR_COMP_EN
  localparam logic [PW-1:0] COMP = (TRUNC > 0)
                                   ? ({{(PW-1){1'b0}}, 1'b1} << ((TRUNC > 0) ? (TRUNC - 1) : 0))
                                   : {PW{1'b0}};
`else
  localparam logic [PW-1:0] COMP = {PW{1'b0}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [PW-1:0]      r_mc;
  logic [WIDTH-1:0]   r_mr;
  logic [PW-1:0]      r_acc;
  logic [PW-1:0]      r_p;

  state_t             w_state_nxt;
  logic [PW-1:0]      w_mc_nxt;
  logic [WIDTH-1:0]   w_mr_nxt;
  logic [PW-1:0]      w_acc_nxt;
  logic [PW-1:0]      w_p_nxt;
  logic [PW-1:0]      w_addend;
  logic [PW-1:0]      w_acc_sum;
  logic [WIDTH-1:0]   w_mr_shift;

  // Shift-and-add datapath: current partial product and shifted multiplier.
  always_comb begin
    w_addend   = r_mr[0] ? (r_mc & MASK) : {PW{1'b0}};
    w_acc_sum  = r_acc + w_addend;
    w_mr_shift = r_mr >> 1;
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_mc_nxt    = r_mc;
    w_mr_nxt    = r_mr;
    w_acc_nxt   = r_acc;
    w_p_nxt     = r_p;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_mc_nxt    = {{WIDTH{1'b0}}, bus.in_a};
          w_mr_nxt    = bus.in_b;
          w_acc_nxt   = COMP;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_acc_nxt = w_acc_sum;
        w_mc_nxt  = r_mc << 1;
        w_mr_nxt  = w_mr_shift;
        // Early termination: the final sum is captured straight into the
        // output register so out_p is valid on the same edge as out_valid.
        if (w_mr_shift == {WIDTH{1'b0}}) begin
          w_p_nxt     = w_acc_sum;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mc    <= {PW{1'b0}};
      r_mr    <= {WIDTH{1'b0}};
      r_acc   <= {PW{1'b0}};
      r_p     <= {PW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_mc    <= w_mc_nxt;
      r_mr    <= w_mr_nxt;
      r_acc   <= w_acc_nxt;
      r_p     <= w_p_nxt;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.out_p     = r_p;

endmodule

// File: tb/tb_approx_mul_seq.sv
// tb_approx_mul_seq: directed self-checking bench for approx_mul_seq.
// Three instances: 8x8 TRUNC=4, 8x8 TRUNC=0 and 12x12 TRUNC=5. A select
// value routes the shared stimulus to one instance at a time.
module tb_approx_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        tb_valid;
  logic        tb_ready;
  logic [11:0] tb_a;
  logic [11:0] tb_b;
  int          checks = 0;
  int          errors = 0;

`ifdef APPROX_MUL_ERR_COMP_EN
  localparam int C4 = 8;
  localparam int C5 = 16;
`else
  localparam int C4 = 0;
  localparam int C5 = 0;
`endif

  always #5 clk = ~clk;

  approx_mul_seq_if #(.WIDTH(8))  if_t4 ();
  approx_mul_seq_if #(.WIDTH(8))  if_t0 ();
  approx_mul_seq_if #(.WIDTH(12)) if_w12 ();

  assign if_t4.in_valid   = tb_valid && (sel == 2'd0);
  assign if_t4.in_a       = tb_a[7:0];
  assign if_t4.in_b       = tb_b[7:0];
  assign if_t4.out_ready  = tb_ready && (sel == 2'd0);
  assign if_t0.in_valid   = tb_valid && (sel == 2'd1);
  assign if_t0.in_a       = tb_a[7:0];
  assign if_t0.in_b       = tb_b[7:0];
  assign if_t0.out_ready  = tb_ready && (sel == 2'd1);
  assign if_w12.in_valid  = tb_valid && (sel == 2'd2);
  assign if_w12.in_a      = tb_a;
  assign if_w12.in_b      = tb_b;
  assign if_w12.out_ready = tb_ready && (sel == 2'd2);

  approx_mul_seq #(.WIDTH(8),  .TRUNC(4)) u_t4  (.clk(clk), .rst_n(rst_n), .bus(if_t4.slave));
  approx_mul_seq #(.WIDTH(8),  .TRUNC(0)) u_t0  (.clk(clk), .rst_n(rst_n), .bus(if_t0.slave));
  approx_mul_seq #(.WIDTH(12), .TRUNC(5)) u_w12 (.clk(clk), .rst_n(rst_n), .bus(if_w12.slave));

  logic        obs_valid;
  logic        obs_in_ready;
  logic        obs_busy;
  logic [23:0] obs_p;

  // Route the selected instance's outputs to the observation signals.
  always_comb begin
    obs_valid    = if_t4.out_valid;
    obs_in_ready = if_t4.in_ready;
    obs_busy     = if_t4.busy;
    obs_p        = {8'd0, if_t4.out_p};
    case (sel)
      2'd1: begin
        obs_valid    = if_t0.out_valid;
        obs_in_ready = if_t0.in_ready;
        obs_busy     = if_t0.busy;
        obs_p        = {8'd0, if_t0.out_p};
      end
      2'd2: begin
        obs_valid    = if_w12.out_valid;
        obs_in_ready = if_w12.in_ready;
        obs_busy     = if_w12.busy;
        obs_p        = if_w12.out_p;
      end
      default: begin
        obs_valid    = if_t4.out_valid;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference for the 12x12 TRUNC=5 instance, written from the result formula.
  function automatic int ref12(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] acc;
    logic [23:0] mask;
    logic [23:0] aa;
    mask = 24'hFF_FFE0;
    aa   = {12'd0, a};
    acc  = 24'(C5);
    for (int i = 0; i < 12; i++) begin
      if (b[i]) acc = acc + ((aa << i) & mask);
    end
    return int'(acc);
  endfunction

  function automatic int lat_of(input logic [11:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 12; i++) begin
      if (b[i]) n = i + 1;
    end
    return n;
  endfunction

  // One transaction: accept, count latency, optional backpressure, handshake.
  task automatic transact(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input int exp_p, input int exp_lat, input int hold);
    int w;
    int cnt;
    w = 0;
    while (!obs_in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    tb_a     = a;
    tb_b     = b;
    tb_valid = 1'b1;
    tb_ready = (hold == 0);
    @(posedge clk); #1;
    tb_valid = 1'b0;
    check({tag, "_busy"}, 32'(obs_busy), 32'd1);
    cnt = 0;
    do begin
      @(posedge clk); #1; cnt++;
    end while (!obs_valid && cnt < 40);
    check({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
    check({tag, "_p"}, 32'(obs_p), 32'(exp_p));
    for (int h = 0; h < hold; h++) begin
      tb_valid = h[0];
      tb_a     = 12'($urandom);
      tb_b     = 12'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_p"}, 32'(obs_p), 32'(exp_p));
      check({tag, "_hold_v"}, 32'(obs_valid), 32'd1);
      check({tag, "_hold_rdy"}, 32'(obs_in_ready), 32'd0);
    end
    tb_valid = 1'b0;
    tb_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_hs_v"}, 32'(obs_valid), 32'd0);
    check({tag, "_hs_rdy"}, 32'(obs_in_ready), 32'd1);
    if (hold > 0) begin
      @(posedge clk); #1;
      check({tag, "_noaccept"}, 32'(obs_busy), 32'd0);
    end
  endtask

  initial begin
    int seen;
    logic [11:0] ra;
    logic [11:0] rb;
    sel      = 2'd0;
    tb_valid = 1'b0;
    tb_ready = 1'b0;
    tb_a     = 12'd0;
    tb_b     = 12'd0;
    rst_n    = 1'b0;
    #12;
    check("rst_in_ready", 32'(obs_in_ready), 32'd1);
    check("rst_out_valid", 32'(obs_valid), 32'd0);
    check("rst_busy", 32'(obs_busy), 32'd0);
    check("rst_out_p", 32'(obs_p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8x8, TRUNC=4
    sel = 2'd0;
    transact("t4_ff", 12'd255, 12'd255, 64976 + C4, 8, 0);
    transact("t4_b1", 12'd13, 12'd1, C4, 1, 0);
    transact("t4_bp", 12'd255, 12'd255, 64976 + C4, 8, 5);

    // 8x8, TRUNC=0: exact product
    sel = 2'd1;
    transact("t0_200x100", 12'd200, 12'd100, 20000, 7, 0);
    transact("t0_b0", 12'd200, 12'd0, 0, 1, 0);

    // Reset in the middle of RUN
    sel      = 2'd0;
    tb_a     = 12'd255;
    tb_b     = 12'd128;
    tb_valid = 1'b1;
    tb_ready = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(obs_valid), 32'd0);
    check("mrst_busy", 32'(obs_busy), 32'd0);
    check("mrst_out_p", 32'(obs_p), 32'd0);
    check("mrst_in_ready", 32'(obs_in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (obs_valid) seen = 1;
    end
    check("mrst_no_emit", 32'(seen), 32'd0);
    transact("t4_3x5", 12'd3, 12'd5, C4, 3, 0);
    sel = 2'd1;
    transact("t0_3x5", 12'd3, 12'd5, 15, 3, 0);

    // 12x12, TRUNC=5
    sel = 2'd2;
    transact("w12_max", 12'hFFF, 12'hFFF, ref12(12'hFFF, 12'hFFF), 12, 0);
    transact("w12_b0", 12'hABC, 12'd0, C5, 1, 0);
    for (int k = 0; k < 300; k++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      if (k % 7 == 0) rb = rb >> $urandom_range(11, 1);
      transact("w12_rnd", ra, rb, ref12(ra, rb), lat_of(rb), int'($urandom_range(2, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
